cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Writeback arbiter that shares the single common data bus (CDB) between the backend functional units: ALU, multiplier, divider, branch and load. Each unit presents a registered reply through the standard valid/ready handshake. The arbiter grants one unit per cycle in round-robin order and latches the winner into a one-entry CDB output register. It applies EBR branch-bus clean/kill updates to the word it captures and to the word it holds, so no killed instruction is ever broadcast.

## Interface
- `N_REQ`, default 4: number of requesting functional units (2..8).
- `clk` input, 1: clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `brif` brb_itf.req: EBR branch bus (`broadcast`, `tag`, `clean`, `kill`).
- `req_valid` input, [N_REQ-1:0]: unit i has a reply pending (unit's `ovalid`).
- `req_stage` input, issue_stage_t [N_REQ]: metadata of each unit's reply.
- `req_result` input, [N_REQ-1:0][31:0]: result of each unit's reply.
- `req_ready` output, [N_REQ-1:0]: reply i consumed this cycle (drives unit's `oready`).
- `cdb_valid` output, 1: CDB word valid.
- `cdb_stage` output, issue_stage_t: metadata of broadcast word.
- `cdb_result` output, [31:0]: broadcast result.
- `cdb_ready` input, 1: ROB/reservation stations accept the CDB word.

## Operation
- `stall = cdb_valid & ~cdb_ready`.
- Arbitration is combinational each cycle. The winner is the first i with `req_valid[i]` set, searching from `ptr` upward modulo N_REQ.
- Exactly one `req_ready` bit may be high. `req_ready[i] = winner_found & (i == winner) & ~stall`.
- Capture on `~stall`:
  - `cdb_valid <= winner_found`.
  - `cdb_stage <= req_stage[winner]` and `cdb_result <= req_result[winner]`. These registers may hold old data when nothing is granted.
- Pointer: `ptr <= (winner+1) mod N_REQ` on a grant. It is unchanged when there is no grant or when stalled.
- Branch bus while capturing (`~stall`, grant, `broadcast`, `req_stage[winner].meta.branch_mask[tag]` set):
  - `clean`: the captured mask bit is cleared.
  - `kill`: the reply is still consumed (`req_ready` high) and `cdb_valid <= 0`.
- Branch bus while holding (stall, or a valid word with no new capture, and the held mask bit set):
  - `clean`: clear the held mask bit.
  - `kill`: `cdb_valid <= 0`. A killed word frees the register next cycle.
- When `clean` and `kill` are both asserted, `clean` wins. This matches the FU convention.
- Requests whose mask hits a kill but that are not granted are left to the requesting unit. The unit drops its own `ovalid`.

## Timing
- Reset, asynchronous on `rst_n` low:
  - `cdb_valid = 0`, `cdb_stage = '0`, `cdb_result = 0`, `ptr = 0`.
  - `req_ready = 0` combinationally, because the winner search sees `req_valid` masked only by stall. Units hold `ovalid = 0` in reset.
- Latency: a request granted in cycle t appears on the CDB in cycle t+1.
- Throughput: one word per cycle with `cdb_ready` held high.
- Back-to-back grants are allowed while `cdb_ready = 1`. The output register refills in the same cycle it drains.
- Stall: all `req_ready` are low. The held word and `ptr` are frozen, except for branch-bus updates.
- Wrap-around: with `ptr = N_REQ-1`, the search order is N_REQ-1, 0, 1, and so on.
- Fairness: any continuously valid request is granted within N_REQ non-stalled cycles.

## Structure
- The following live in `backend_types`: `issue_stage_t`, `brb_itf`, and a new `cdb_t` struct holding `stage` and `result`. The parameter default constant `CDB_N_REQ` also goes there.
- Sub-module `rr_arbiter`:
  - Parameterised N.
  - Inputs: `req`, `ptr`. Outputs: one-hot `gnt`, `gnt_idx`, `any`.
  - Purely combinational.
  - `cdb_arbiter` owns `ptr`, the output register and the branch-bus logic.

## Test plan
- Reset mid-stream: assert `rst_n = 0` while `cdb_valid = 1` -> `cdb_valid` and `ptr` clear immediately. After release, the first grant goes to unit 0.
- Round-robin: all 4 units valid, `cdb_ready = 1` for 8 cycles -> grants are 0,1,2,3,0,1,2,3. The CDB shows the matching results one cycle later.
- Backpressure: `cdb_ready = 0` for 3 cycles with the CDB holding result 0xDEAD_BEEF -> `req_ready = 0`, the word is stable and `ptr` is unchanged. On release the next winner is captured in the same cycle.
- Kill on capture: unit 2 is the winner with mask bit 1 set, and the bus sends `kill`, tag 1 -> `req_ready[2] = 1`, and the next cycle has `cdb_valid = 0`.
- Clean on hold: stalled word with mask `4'b0101`, bus sends `clean`, tag 2 -> the held mask becomes `4'b0001` and `cdb_valid` stays 1.
- Sparse requests: only unit 3 is valid, with `ptr = 0` -> unit 3 is granted and `ptr` becomes 0 (wrap).

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - backend types shared by the CDB writeback arbiter
package backend_types;

   localparam int CDB_N_REQ = 4;
   localparam int BR_TAGS   = 4;
   localparam int BR_TAG_W  = $clog2(BR_TAGS);
   localparam int ROB_IDX_W = 5;

   typedef struct packed {
      logic [BR_TAGS-1:0]   branch_mask;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [4:0]           rd;
   } stage_meta_t;

   typedef struct packed {
      stage_meta_t meta;
      logic [3:0]  fu_op;
   } issue_stage_t;

   typedef struct packed {
      issue_stage_t stage;
      logic [31:0]  result;
   } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - EBR branch bus carrying clean/kill updates by branch tag
interface brb_itf;
   import backend_types::*;

   logic                broadcast;
   logic [BR_TAG_W-1:0] tag;
   logic                clean;
   logic                kill;

   modport drv (output broadcast, tag, clean, kill);
   modport req (input  broadcast, tag, clean, kill);
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational round-robin search from ptr upward
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any
);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         // modulo-N add without a divider: ptr < N and k < N, so one subtract suffices
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N))
            sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (!any && req[idx]) begin
            any     = 1'b1;
            gnt_idx = idx;
         end
      end
      if (any)
         gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin writeback arbiter driving the one-entry CDB register
module cdb_arbiter
   import backend_types::*;
#(
   parameter int N_REQ = CDB_N_REQ
) (
   input  logic                   clk,
   input  logic                   rst_n,
   brb_itf.req                    brif,
   input  logic [N_REQ-1:0]       req_valid,
   input  issue_stage_t           req_stage [N_REQ],
   input  logic [N_REQ-1:0][31:0] req_result,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   cdb_valid,
   output issue_stage_t           cdb_stage,
   output logic [31:0]            cdb_result,
   input  logic                   cdb_ready
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    ptr;
   logic [PW-1:0]    winner;
   logic [PW-1:0]    ptr_next;
   logic             winner_found;
   logic             stall;
   logic [N_REQ-1:0] gnt;
   logic             br_clean;
   logic             br_kill;
   logic             cap_kill;
   logic             hold_kill;
   cdb_t             cdb_q;
   cdb_t             cap_word;
   cdb_t             hold_word;

   assign stall = cdb_valid & ~cdb_ready;

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (winner),
      .any     (winner_found)
   );

   assign req_ready = (winner_found && !stall) ? gnt : '0;
   assign ptr_next  = (winner == PW'(N_REQ-1)) ? '0 : winner + 1'b1;

   // clean has priority over kill when both are raised for the same tag
   assign br_clean = brif.broadcast & brif.clean;
   assign br_kill  = brif.broadcast & brif.kill & ~brif.clean;

   always_comb begin
      cap_word.stage  = req_stage[winner];
      cap_word.result = req_result[winner];
      hold_word       = cdb_q;
      if (br_clean) begin
         cap_word.stage.meta.branch_mask[brif.tag]  = 1'b0;
         hold_word.stage.meta.branch_mask[brif.tag] = 1'b0;
      end
      cap_kill  = br_kill & req_stage[winner].meta.branch_mask[brif.tag];
      hold_kill = br_kill & cdb_q.stage.meta.branch_mask[brif.tag];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_valid <= 1'b0;
         cdb_q     <= '0;
         ptr       <= '0;
      end else if (!stall) begin
         // a killed winner is still consumed so the unit can retire its slot
         cdb_valid <= winner_found & ~cap_kill;
         if (winner_found) begin
            cdb_q <= cap_word;
            ptr   <= ptr_next;
         end
      end else begin
         cdb_q <= hold_word;
         if (hold_kill)
            cdb_valid <= 1'b0;
      end
   end

   assign cdb_stage  = cdb_q.stage;
   assign cdb_result = cdb_q.result;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
   import backend_types::*;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [3:0]          req_valid;
   issue_stage_t        req_stage [4];
   logic [3:0][31:0]    req_result;
   logic [3:0]          req_ready;
   logic                cdb_valid;
   issue_stage_t        cdb_stage;
   logic [31:0]         cdb_result;
   logic                cdb_ready;
   int                  checks = 0;
   int                  errors = 0;

   brb_itf bb ();

   cdb_arbiter #(.N_REQ(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .brif       (bb),
      .req_valid  (req_valid),
      .req_stage  (req_stage),
      .req_result (req_result),
      .req_ready  (req_ready),
      .cdb_valid  (cdb_valid),
      .cdb_stage  (cdb_stage),
      .cdb_result (cdb_result),
      .cdb_ready  (cdb_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_rdy;
      rst_n         = 1'b0;
      req_valid     = '0;
      cdb_ready     = 1'b1;
      bb.broadcast  = 1'b0;
      bb.tag        = '0;
      bb.clean      = 1'b0;
      bb.kill       = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_stage[i]         = '0;
         req_stage[i].meta.rd = 5'(i + 1);
         req_result[i]        = 32'h100 + 32'(i);
      end

      tick();
      tick();
      chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("rst_cdb_result", 64'(cdb_result), 64'd0);
      chk("rst_cdb_stage", 64'(cdb_stage), 64'd0);
      chk("rst_ptr", 64'(dut.ptr), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);

      rst_n     = 1'b1;
      req_valid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         exp_rdy = 4'b0001 << (c % 4);
         chk("rr_req_ready", 64'(req_ready), 64'(exp_rdy));
         tick();
         chk("rr_cdb_valid", 64'(cdb_valid), 64'd1);
         chk("rr_cdb_result", 64'(cdb_result), 64'h100 + 64'(c % 4));
      end
      chk("rr_ptr_wrapped", 64'(dut.ptr), 64'd0);

      req_valid     = 4'b0010;
      req_result[1] = 32'hDEAD_BEEF;
      #1;
      chk("bp_setup_ready", 64'(req_ready), 64'h2);
      tick();
      chk("bp_setup_result", 64'(cdb_result), 64'hDEAD_BEEF);
      chk("bp_setup_ptr", 64'(dut.ptr), 64'd2);
      cdb_ready     = 1'b0;
      req_valid     = 4'hF;
      req_result[1] = 32'h101;
      #1;
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("bp_hold_result", 64'(cdb_result), 64'hDEAD_BEEF);
         chk("bp_hold_valid", 64'(cdb_valid), 64'd1);
         chk("bp_hold_ptr", 64'(dut.ptr), 64'd2);
         chk("bp_hold_ready", 64'(req_ready), 64'd0);
      end
      cdb_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(req_ready), 64'h4);
      tick();
      chk("bp_release_result", 64'(cdb_result), 64'h102);
      chk("bp_release_ptr", 64'(dut.ptr), 64'd3);

      req_valid                      = 4'b0100;
      req_stage[2].meta.branch_mask  = 4'b0010;
      bb.broadcast = 1'b1;
      bb.tag       = 2'd1;
      bb.kill      = 1'b1;
      #1;
      chk("kc_req_ready", 64'(req_ready), 64'h4);
      tick();
      chk("kc_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("kc_ptr", 64'(dut.ptr), 64'd3);
      bb.broadcast                  = 1'b0;
      bb.kill                       = 1'b0;
      req_stage[2].meta.branch_mask = 4'b0000;

      req_valid                     = 4'b0001;
      req_stage[0].meta.branch_mask = 4'b0101;
      req_result[0]                 = 32'h55;
      #1;
      chk("ch_req_ready", 64'(req_ready), 64'h1);
      tick();
      chk("ch_cap_valid", 64'(cdb_valid), 64'd1);
      chk("ch_cap_mask", 64'(cdb_stage.meta.branch_mask), 64'h5);
      chk("ch_cap_ptr", 64'(dut.ptr), 64'd1);
      cdb_ready    = 1'b0;
      req_valid    = '0;
      bb.broadcast = 1'b1;
      bb.tag       = 2'd2;
      bb.clean     = 1'b1;
      tick();
      chk("ch_clean_mask", 64'(cdb_stage.meta.branch_mask), 64'h1);
      chk("ch_clean_valid", 64'(cdb_valid), 64'd1);
      bb.tag  = 2'd0;
      bb.kill = 1'b1;
      tick();
      chk("ch_both_mask", 64'(cdb_stage.meta.branch_mask), 64'h0);
      chk("ch_both_valid", 64'(cdb_valid), 64'd1);
      bb.clean = 1'b0;
      tick();
      chk("ch_kill_miss_valid", 64'(cdb_valid), 64'd1);
      chk("ch_kill_miss_result", 64'(cdb_result), 64'h55);
      bb.broadcast                  = 1'b0;
      bb.kill                       = 1'b0;
      req_stage[0].meta.branch_mask = 4'b0000;
      req_result[0]                 = 32'h100;

      cdb_ready                     = 1'b1;
      req_valid                     = 4'b0010;
      req_stage[1].meta.branch_mask = 4'b1000;
      #1;
      chk("kh_req_ready", 64'(req_ready), 64'h2);
      tick();
      chk("kh_cap_valid", 64'(cdb_valid), 64'd1);
      chk("kh_cap_ptr", 64'(dut.ptr), 64'd2);
      cdb_ready    = 1'b0;
      req_valid    = '0;
      bb.broadcast = 1'b1;
      bb.tag       = 2'd3;
      bb.kill      = 1'b1;
      tick();
      chk("kh_cdb_valid", 64'(cdb_valid), 64'd0);
      bb.broadcast                  = 1'b0;
      bb.kill                       = 1'b0;
      req_stage[1].meta.branch_mask = 4'b0000;
      cdb_ready                     = 1'b1;

      tick();
      chk("idle_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("idle_ptr", 64'(dut.ptr), 64'd2);

      req_valid = 4'b1000;
      #1;
      chk("sp_ready_a", 64'(req_ready), 64'h8);
      tick();
      chk("sp_ptr_a", 64'(dut.ptr), 64'd0);
      #1;
      chk("sp_ready_b", 64'(req_ready), 64'h8);
      tick();
      chk("sp_ptr_b", 64'(dut.ptr), 64'd0);
      chk("sp_result", 64'(cdb_result), 64'h103);
      chk("sp_rd", 64'(cdb_stage.meta.rd), 64'd4);

      req_valid = 4'b0001;
      tick();
      chk("mr_pre_valid", 64'(cdb_valid), 64'd1);
      chk("mr_pre_ptr", 64'(dut.ptr), 64'd1);
      #2;
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      chk("mr_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("mr_ptr", 64'(dut.ptr), 64'd0);
      chk("mr_cdb_result", 64'(cdb_result), 64'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("mr_first_ready", 64'(req_ready), 64'h1);
      tick();
      chk("mr_first_result", 64'(cdb_result), 64'h100);
      chk("mr_first_ptr", 64'(dut.ptr), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
